mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Main control FSM for the multicycle MIPS-32 datapath. Sequences fetch/decode/execute/memory/writeback.
//  Drives datapath mux selects, write enables and the 2-bit alu_op consumed by alu_control_32.
//  Memory accesses stall on a ready handshake. Sits between the instruction register opcode/func fields and the datapath.
// PARAMETERS
//  OPW      6  opcode field width
//  FNW      6  func field width
// PORTS
//  clk                  in   1  system clock; all state changes on rising edge
//  reset                in   1  synchronous, active-high reset
//  opcode               in   6  IR[31:26]; sampled in DECODE only
//  func                 in   6  IR[5:0]; sampled in DECODE only (jr detect)
//  zero                 in   1  ALU zero flag (beq)
//  mem_ready            in   1  memory completes current access this cycle
//  alu_func_err         in   1  err_illegal_func_code from alu_control_32
//  pc_write             out  1  unconditional PC load
//  pc_write_cond        out  1  PC load qualified by zero (beq)
//  i_or_d               out  1  0=PC addresses memory, 1=ALUOut
//  mem_read, mem_write  out  1  memory strobes; held until mem_ready
//  ir_write             out  1  load instruction register
//  reg_dst              out  1  0=rt, 1=rd
//  mem_to_reg           out  1  0=ALUOut, 1=MDR
//  reg_write            out  1  register file write enable
//  alu_src_a            out  1  0=PC, 1=A
//  alu_src_b            out  2  00=B 01=const 4 10=signext imm 11=signext imm<<2
//  alu_op               out  2  00=add(mem/addi) 01=sub(branch) 10=R-type func decode
//  pc_source            out  2  00=ALU result 01=ALUOut 10=jump target 11=A (jr)
//  instr_done           out  1  one-cycle pulse on the last cycle of every instruction
//  halted               out  1  sticky trap flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0, halted=0. IDLE -> FETCH next cycle unconditionally.
//  - States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP, JR, TRAP.
//  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
//    ir_write and pc_write are asserted only in the cycle mem_ready=1 (Mealy); then -> DECODE. Otherwise stay in FETCH.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
//    lw 100011/sw 101011 -> MEM_ADDR; R 000000 -> JR if func=001000, else R_EXEC.
//    beq 000100 -> BRANCH; j 000010 -> JUMP; addi 001000 -> ADDI_EXEC; other -> illegal (see CONFIGURATION).
//  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. -> MEM_RD (lw) or MEM_WR (sw); the opcode is latched in DECODE.
//  - MEM_RD: mem_read=1, i_or_d=1; wait for mem_ready, then -> MEM_WB.
//  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
//  - MEM_WR: mem_write=1, i_or_d=1; wait for mem_ready; done on the ready cycle.
//  - R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. If alu_func_err=1 -> illegal handling; else -> R_WB.
//  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0.
//  - ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB. ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0.
//  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
//  - JUMP: pc_write=1, pc_source=10. JR: pc_write=1, pc_source=11.
//  - Terminal states (MEM_WB, MEM_WR on ready, R_WB, ADDI_WB, BRANCH, JUMP, JR): instr_done=1 for that cycle, -> FETCH.
//  - All outputs not listed for a state are 0. Strobes are never asserted in two states simultaneously.
//  - mem_ready is ignored outside FETCH/MEM_RD/MEM_WR. A stall of unbounded length holds every output stable.
//  - reset has priority over all transitions, including mid-stall; the next cycle is IDLE with outputs 0.
// CONFIGURATION
//  - ILLEGAL_OP_TRAP_EN defined: illegal opcode (DECODE) or alu_func_err (R_EXEC) -> TRAP.
//    TRAP: all strobes 0, halted=1 sticky; only reset exits.
//  - Undefined: the illegal instruction is a NOP: -> FETCH with instr_done=1, no register/memory/PC write; halted tied 0.
// STRUCTURE
//  - mips_pkg: opcode/func localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, FN_JR),
//    ALUOP_ADD/SUB/RTYPE, PCSRC_*, ALUSRCB_*, state encoding (4-bit).
//  - One sub-module: mips_ctrl_outdec (combinational state+mem_ready -> control word).
//    The top holds the state register and next-state logic.
// TESTING
//  - reset=1 for 2 cycles, then release, mem_ready=1 -> cycle0 IDLE with all outputs 0;
//    cycle1 FETCH with ir_write=pc_write=1, alu_op=00.
//  - lw (opcode 100011), mem_ready low 3 cycles in MEM_RD -> mem_read,i_or_d held 3 cycles;
//    MEM_WB reg_write=1, mem_to_reg=1; instr_done after 5 states + stalls.
//  - add R-type (func 100000) -> R_EXEC alu_op=10, R_WB reg_write=1, reg_dst=1;
//    jr (func 001000) -> JR pc_write=1, pc_source=11.
//  - beq with zero=1 and with zero=0 -> BRANCH alu_op=01, pc_write_cond=1, pc_source=01 in both cases;
//    the next state is FETCH.
//  - opcode 111111: with ILLEGAL_OP_TRAP_EN -> halted=1, stays until reset;
//    without it -> instr_done=1, next state FETCH, no writes.
//  - assert reset during a MEM_WR stall -> mem_write drops the next cycle, state IDLE, then normal fetch.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS-32 controller: opcodes, select encodings,
// FSM state encoding and the packed control word produced by the output decoder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    localparam logic [1:0] ALUSRCB_B       = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_FETCH     = 4'd1;
    localparam logic [3:0] ST_DECODE    = 4'd2;
    localparam logic [3:0] ST_MEM_ADDR  = 4'd3;
    localparam logic [3:0] ST_MEM_RD    = 4'd4;
    localparam logic [3:0] ST_MEM_WB    = 4'd5;
    localparam logic [3:0] ST_MEM_WR    = 4'd6;
    localparam logic [3:0] ST_R_EXEC    = 4'd7;
    localparam logic [3:0] ST_R_WB      = 4'd8;
    localparam logic [3:0] ST_ADDI_EXEC = 4'd9;
    localparam logic [3:0] ST_ADDI_WB   = 4'd10;
    localparam logic [3:0] ST_BRANCH    = 4'd11;
    localparam logic [3:0] ST_JUMP      = 4'd12;
    localparam logic [3:0] ST_JR        = 4'd13;
    localparam logic [3:0] ST_TRAP      = 4'd14;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_word_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: legal = 1'b1;
            default:                                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave):
// instruction fields and status in, mux selects and strobes out.
interface mips_multicycle_ctrl_if #(
    parameter int OPW = 6,
    parameter int FNW = 6
);
    logic [OPW-1:0] opcode;
    logic [FNW-1:0] func;
    logic           zero;
    logic           mem_ready;
    logic           alu_func_err;

    logic           pc_write;
    logic           pc_write_cond;
    logic           i_or_d;
    logic           mem_read;
    logic           mem_write;
    logic           ir_write;
    logic           reg_dst;
    logic           mem_to_reg;
    logic           reg_write;
    logic           alu_src_a;
    logic [1:0]     alu_src_b;
    logic [1:0]     alu_op;
    logic [1:0]     pc_source;
    logic           instr_done;
    logic           halted;

    modport master (
        input  opcode, func, zero, mem_ready, alu_func_err,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, halted
    );

    modport slave (
        output opcode, func, zero, mem_ready, alu_func_err,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, halted
    );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// Combinational output decoder: FSM state plus mem_ready (Mealy strobes) to control word.
module mips_ctrl_outdec
    import mips_pkg::*;
(
    input  logic [3:0]  state_i,
    input  logic        mem_ready_i,
    input  logic        nop_done_i,
    output ctrl_word_t  cw_o
);

    // Per-state control word; anything not set stays 0.
    always_comb begin
        cw_o = '0;
        case (state_i)
            ST_FETCH: begin
                cw_o.mem_read  = 1'b1;
                cw_o.alu_src_b = ALUSRCB_FOUR;
                cw_o.alu_op    = ALUOP_ADD;
                cw_o.pc_source = PCSRC_ALU;
                cw_o.ir_write  = mem_ready_i;
                cw_o.pc_write  = mem_ready_i;
            end
            ST_DECODE: begin
                cw_o.alu_src_b  = ALUSRCB_IMM_SH2;
                cw_o.alu_op     = ALUOP_ADD;
                cw_o.instr_done = nop_done_i;
            end
            ST_MEM_ADDR, ST_ADDI_EXEC: begin
                cw_o.alu_src_a = 1'b1;
                cw_o.alu_src_b = ALUSRCB_IMM;
                cw_o.alu_op    = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                cw_o.mem_read = 1'b1;
                cw_o.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                cw_o.reg_write  = 1'b1;
                cw_o.mem_to_reg = 1'b1;
                cw_o.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                cw_o.mem_write  = 1'b1;
                cw_o.i_or_d     = 1'b1;
                cw_o.instr_done = mem_ready_i;
            end
            ST_R_EXEC: begin
                cw_o.alu_src_a  = 1'b1;
                cw_o.alu_src_b  = ALUSRCB_B;
                cw_o.alu_op     = ALUOP_RTYPE;
                cw_o.instr_done = nop_done_i;
            end
            ST_R_WB: begin
                cw_o.reg_write  = 1'b1;
                cw_o.reg_dst    = 1'b1;
                cw_o.instr_done = 1'b1;
            end
            ST_ADDI_WB: begin
                cw_o.reg_write  = 1'b1;
                cw_o.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                cw_o.alu_src_a     = 1'b1;
                cw_o.alu_src_b     = ALUSRCB_B;
                cw_o.alu_op        = ALUOP_SUB;
                cw_o.pc_write_cond = 1'b1;
                cw_o.pc_source     = PCSRC_ALUOUT;
                cw_o.instr_done    = 1'b1;
            end
            ST_JUMP: begin
                cw_o.pc_write   = 1'b1;
                cw_o.pc_source  = PCSRC_JUMP;
                cw_o.instr_done = 1'b1;
            end
            ST_JR: begin
                cw_o.pc_write   = 1'b1;
                cw_o.pc_source  = PCSRC_REG;
                cw_o.instr_done = 1'b1;
            end
            default: cw_o = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS-32 datapath (state register + next-state logic).
// Define ILLEGAL_OP_TRAP_EN to trap on illegal opcodes / alu_func_err; otherwise they retire as NOPs.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int OPW = 6,
    parameter int FNW = 6
)(
    input  logic                  clk,
    input  logic                  reset,
    mips_multicycle_ctrl_if.master ctrl
);

`ifdef ILLEGAL_OP_TRAP_EN
    localparam logic [3:0] ST_ILLEGAL = ST_TRAP;
`else
    localparam logic [3:0] ST_ILLEGAL = ST_FETCH;
`endif

    logic [3:0]     state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic           nop_done_s;
    ctrl_word_t     cw_s;
    logic           unused_zero_s;

    // zero only qualifies pc_write_cond inside the datapath
    assign unused_zero_s = ctrl.zero;

`ifdef ILLEGAL_OP_TRAP_EN
    assign nop_done_s  = 1'b0;
    assign ctrl.halted = (state_q == ST_TRAP);
`else
    assign nop_done_s  = ((state_q == ST_DECODE) && !is_legal_op(ctrl.opcode)) ||
                         ((state_q == ST_R_EXEC) && ctrl.alu_func_err);
    assign ctrl.halted = 1'b0;
`endif

    // Next-state logic; the opcode is captured in DECODE to steer MEM_ADDR.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (ctrl.mem_ready) state_d = ST_DECODE;
                else                state_d = ST_FETCH;
            end
            ST_DECODE: begin
                op_d = ctrl.opcode;
                case (ctrl.opcode)
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_RTYPE:     state_d = (ctrl.func == FN_JR) ? ST_JR : ST_R_EXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI:      state_d = ST_ADDI_EXEC;
                    default:      state_d = ST_ILLEGAL;
                endcase
            end
            ST_MEM_ADDR: state_d = (op_q == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (ctrl.mem_ready) state_d = ST_MEM_WB;
                else                state_d = ST_MEM_RD;
            end
            ST_MEM_WR: begin
                if (ctrl.mem_ready) state_d = ST_FETCH;
                else                state_d = ST_MEM_WR;
            end
            ST_R_EXEC: begin
                if (ctrl.alu_func_err) state_d = ST_ILLEGAL;
                else                   state_d = ST_R_WB;
            end
            ST_ADDI_EXEC: state_d = ST_ADDI_WB;
            ST_MEM_WB, ST_R_WB, ST_ADDI_WB, ST_BRANCH, ST_JUMP, ST_JR: state_d = ST_FETCH;
            ST_TRAP:  state_d = ST_TRAP;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and latched-opcode registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    mips_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (ctrl.mem_ready),
        .nop_done_i  (nop_done_s),
        .cw_o        (cw_s)
    );

    assign ctrl.pc_write      = cw_s.pc_write;
    assign ctrl.pc_write_cond = cw_s.pc_write_cond;
    assign ctrl.i_or_d        = cw_s.i_or_d;
    assign ctrl.mem_read      = cw_s.mem_read;
    assign ctrl.mem_write     = cw_s.mem_write;
    assign ctrl.ir_write      = cw_s.ir_write;
    assign ctrl.reg_dst       = cw_s.reg_dst;
    assign ctrl.mem_to_reg    = cw_s.mem_to_reg;
    assign ctrl.reg_write     = cw_s.reg_write;
    assign ctrl.alu_src_a     = cw_s.alu_src_a;
    assign ctrl.alu_src_b     = cw_s.alu_src_b;
    assign ctrl.alu_op        = cw_s.alu_op;
    assign ctrl.pc_source     = cw_s.pc_source;
    assign ctrl.instr_done    = cw_s.instr_done;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks lw/sw/R/jr/beq/j/addi/illegal sequences
// and compares the full 18-bit control vector against hand-computed values each cycle.
module tb_mips_multicycle_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mips_multicycle_ctrl_if #(.OPW(6), .FNW(6)) dut_if ();

    mips_multicycle_ctrl #(.OPW(6), .FNW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (dut_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector order: pcw pcwc iord mr mw irw rdst m2r rw asa asb[2] aop[2] psrc[2] done halted
    localparam logic [17:0] V_ZERO   = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] V_FET_R  = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] V_FET_S  = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] V_DEC    = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [17:0] V_DEC_NP = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_0;
    localparam logic [17:0] V_MADDR  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] V_MRD    = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] V_MWB    = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
    localparam logic [17:0] V_MWR_S  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] V_MWR_R  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
    localparam logic [17:0] V_REX    = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [17:0] V_RWB    = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
    localparam logic [17:0] V_AWB    = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
    localparam logic [17:0] V_BR     = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [17:0] V_J      = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
    localparam logic [17:0] V_JR     = 18'b1_0_0_0_0_0_0_0_0_0_00_00_11_1_0;
    localparam logic [17:0] V_TRAP   = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;

    function automatic logic [17:0] obs_vec();
        return {dut_if.pc_write, dut_if.pc_write_cond, dut_if.i_or_d, dut_if.mem_read,
                dut_if.mem_write, dut_if.ir_write, dut_if.reg_dst, dut_if.mem_to_reg,
                dut_if.reg_write, dut_if.alu_src_a, dut_if.alu_src_b, dut_if.alu_op,
                dut_if.pc_source, dut_if.instr_done, dut_if.halted};
    endfunction

    task automatic check_eq(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%b exp=%b", tag, obs, exp);
        end
    endtask

    // Drive mem_ready at the falling edge, check the settled outputs, advance one cycle.
    task automatic step(input string tag, input logic rdy, input logic [17:0] exp);
        dut_if.mem_ready = rdy;
        #1;
        check_eq(tag, obs_vec(), exp);
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
        dut_if.opcode = op;
        dut_if.func   = fn;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        dut_if.opcode       = 6'b000000;
        dut_if.func         = 6'b000000;
        dut_if.zero         = 1'b0;
        dut_if.mem_ready    = 1'b1;
        dut_if.alu_func_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        step("reset", 1'b1, V_ZERO);
        reset = 1'b0;
        step("idle", 1'b1, V_ZERO);

        // lw with a 3-cycle read stall
        set_instr(6'b100011, 6'b000000);
        step("lw_fetch", 1'b1, V_FET_R);
        step("lw_decode", 1'b0, V_DEC);
        step("lw_maddr", 1'b1, V_MADDR);
        for (int i = 0; i < 3; i++) step("lw_mrd_stall", 1'b0, V_MRD);
        step("lw_mrd_rdy", 1'b1, V_MRD);
        step("lw_mwb", 1'b0, V_MWB);

        // add with a fetch stall
        set_instr(6'b000000, 6'b100000);
        step("add_fetch_stall", 1'b0, V_FET_S);
        step("add_fetch", 1'b1, V_FET_R);
        step("add_decode", 1'b1, V_DEC);
        step("add_rexec", 1'b1, V_REX);
        step("add_rwb", 1'b1, V_RWB);

        // jr
        set_instr(6'b000000, 6'b001000);
        step("jr_fetch", 1'b1, V_FET_R);
        step("jr_decode", 1'b1, V_DEC);
        step("jr_jr", 1'b1, V_JR);

        // beq taken and not taken
        set_instr(6'b000100, 6'b000000);
        dut_if.zero = 1'b1;
        step("beq1_fetch", 1'b1, V_FET_R);
        step("beq1_decode", 1'b1, V_DEC);
        step("beq1_branch", 1'b1, V_BR);
        dut_if.zero = 1'b0;
        step("beq0_fetch", 1'b1, V_FET_R);
        step("beq0_decode", 1'b1, V_DEC);
        step("beq0_branch", 1'b1, V_BR);

        // j and addi
        set_instr(6'b000010, 6'b000000);
        step("j_fetch", 1'b1, V_FET_R);
        step("j_decode", 1'b1, V_DEC);
        step("j_jump", 1'b1, V_J);
        set_instr(6'b001000, 6'b000000);
        step("addi_fetch", 1'b1, V_FET_R);
        step("addi_decode", 1'b1, V_DEC);
        step("addi_exec", 1'b1, V_MADDR);
        step("addi_wb", 1'b1, V_AWB);

        // sw: reset lands in the middle of a write stall, then a clean sw
        set_instr(6'b101011, 6'b000000);
        step("sw_fetch", 1'b1, V_FET_R);
        step("sw_decode", 1'b1, V_DEC);
        step("sw_maddr", 1'b1, V_MADDR);
        step("sw_mwr_stall", 1'b0, V_MWR_S);
        reset = 1'b1;
        step("sw_mwr_rst_cyc", 1'b0, V_MWR_S);
        step("sw_after_rst", 1'b0, V_ZERO);
        reset = 1'b0;
        step("sw_idle", 1'b1, V_ZERO);
        step("sw2_fetch", 1'b1, V_FET_R);
        step("sw2_decode", 1'b1, V_DEC);
        step("sw2_maddr", 1'b1, V_MADDR);
        step("sw2_mwr_rdy", 1'b1, V_MWR_R);

        // illegal opcode
        set_instr(6'b111111, 6'b000000);
        step("ill_fetch", 1'b1, V_FET_R);
`ifdef ILLEGAL_OP_TRAP_EN
        step("ill_decode", 1'b1, V_DEC);
        for (int i = 0; i < 3; i++) step("ill_trap", 1'b1, V_TRAP);
        reset = 1'b1;
        step("ill_trap_rst_cyc", 1'b1, V_TRAP);
        reset = 1'b0;
        step("ill_idle", 1'b1, V_ZERO);
        step("ill_refetch", 1'b1, V_FET_R);
`else
        step("ill_decode", 1'b1, V_DEC_NP);
        step("ill_next_fetch", 1'b1, V_FET_R);
        // R-type with illegal func retires as a NOP from R_EXEC
        set_instr(6'b000000, 6'b111111);
        step("rerr_decode", 1'b1, V_DEC);
        dut_if.alu_func_err = 1'b1;
        step("rerr_rexec", 1'b1, {V_REX[17:2], 1'b1, 1'b0});
        dut_if.alu_func_err = 1'b0;
        step("rerr_next_fetch", 1'b1, V_FET_R);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
